input_debouncer: RTL and testbench
==================================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001: Parameter STABLE_CYCLES, default 4, sets the consecutive clock edges a synchronized input must differ from its debounced value before the change is accepted; legal range 2..255.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: sw_in  input  10  raw switch/button levels, asynchronous to clk; bit map 0..5 = gate-1 inputs a..f, 6..9 = gate-2 inputs a..d.
REQ-005: sw_db  output  10  debounced levels, same bit map; drives the downstream AND-OR gate inputs directly.
REQ-006: sw_rise  output  10  one-cycle pulse per bit when sw_db[i] changes 0->1.
REQ-007: sw_fall  output  10  one-cycle pulse per bit when sw_db[i] changes 1->0.
REQ-008: any_chg  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits.

Function
REQ-009: Each bit SHALL pass through a two-flop synchronizer (s1 <= sw_in, s2 <= s1) before any other logic.
REQ-010: Each bit SHALL own an independent 8-bit counter cnt[i]; channels SHALL NOT interact.
REQ-011: On an edge where s2[i] == sw_db[i], cnt[i] SHALL clear to 0 and sw_db[i] SHALL hold.
REQ-012: On an edge where s2[i] != sw_db[i] and cnt[i] < STABLE_CYCLES-1, cnt[i] SHALL increment by 1 and sw_db[i] SHALL hold.
REQ-013: On an edge where s2[i] != sw_db[i] and cnt[i] == STABLE_CYCLES-1, sw_db[i] SHALL load s2[i] and cnt[i] SHALL clear to 0.
REQ-014: sw_rise[i]/sw_fall[i] SHALL be registered, asserted for exactly the one cycle following the edge on which sw_db[i] updated, and never both high for the same bit.
REQ-015: any_chg SHALL be asserted in the same cycle as any sw_rise/sw_fall bit.
REQ-016: Latency: a clean level change on sw_in[i] setting up before edge E1 SHALL appear on sw_db[i] after edge E(STABLE_CYCLES+2) (E6 at default), pulse in the same cycle.
REQ-017: Glitch rejection: a difference lasting fewer than STABLE_CYCLES consecutive edges at s2 SHALL leave sw_db unchanged and produce no pulse; cnt restarts from 0 on any return to agreement.
REQ-018: Counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019: Simultaneous changes on several bits SHALL be handled in parallel; bits accepted on the same edge pulse in the same cycle, any_chg high once for that cycle.
REQ-020: A bit toggling every cycle indefinitely SHALL never update sw_db.

Reset
REQ-021: While rst is high, s1, s2, sw_db, all cnt, sw_rise, sw_fall and any_chg SHALL be 0, asynchronously and independent of clk.
REQ-022: Reset asserted mid-count SHALL discard the partial count; after release a held input requires the full REQ-016 latency again.
REQ-023: After reset release with sw_in = 0, outputs SHALL stay 0 with no pulses.

Verification
REQ-024: Reset, then sw_in = 10'h001 held -> sw_db = 10'h001 after 6th edge, sw_rise = 10'h001 and any_chg = 1 for one cycle, then 0.
REQ-025: sw_db = 10'h3FF stable, sw_in[9] low for 3 cycles then high -> sw_db stays 10'h3FF, no sw_fall, any_chg stays 0.
REQ-026: sw_in 10'h000 -> 10'h2A5 in one step -> sw_db = 10'h2A5 on 6th edge, sw_rise = 10'h2A5 in one cycle, any_chg high one cycle.
REQ-027: sw_in[3] 0 -> 1, rst pulsed high after 4th edge, released, input held -> sw_db[3] = 0 through reset, then rises 6 edges after release.
REQ-028: sw_in[5] toggling every clk for 50 cycles -> sw_db[5] = 0, no pulses; then held 1 -> sw_rise[5] after 6 edges.
REQ-029: STABLE_CYCLES = 2 build, sw_in[0] 0 -> 1 -> sw_db[0] = 1 after 4th edge.

Source files
------------

// File: rtl/input_debouncer.sv
// Ten-channel switch debouncer.
// Each raw input is synchronized through two flops, then must disagree with its
// debounced level for STABLE_CYCLES consecutive edges before the new level is
// accepted. Accepted changes also produce registered one-cycle rise/fall
// pulses and a combined any-change pulse.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw_in,
    output logic [9:0] sw_db,
    output logic [9:0] sw_rise,
    output logic [9:0] sw_fall,
    output logic       any_chg
);

    // Last count value before a disagreeing sample is accepted.
    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

    logic [9:0] s1_q;
    logic [9:0] s2_q;
    logic [9:0] db_q;
    logic [9:0] db_d;
    logic [9:0] rise_q;
    logic [9:0] rise_d;
    logic [9:0] fall_q;
    logic [9:0] fall_d;
    logic       any_q;
    logic       any_d;
    logic [7:0] cnt_q [10];
    logic [7:0] cnt_d [10];

    // Two-flop synchronizer for the asynchronous switch levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw_in;
            s2_q <= s1_q;
        end
    end

    // Per-channel disagreement counter; agreement always restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 10; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                // >= keeps the counter bounded even if it were ever out of range.
                if (cnt_q[i] >= CntMax) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Edge pulses derived from the level about to be registered.
    always_comb begin
        rise_d = db_d & ~db_q;
        fall_d = ~db_d & db_q;
        any_d  = |(rise_d | fall_d);
    end

    // Debounced state, counters and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
            for (int i = 0; i < 10; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db   = db_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign any_chg = any_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: default build (4) and a STABLE_CYCLES=2 build
// share the same stimulus and are each checked against a window-based model.
module tb_input_debouncer;

    logic       clk;
    logic       rst;
    logic [9:0] sw_in;

    logic [9:0] d4_db, d4_rise, d4_fall;
    logic       d4_any;
    logic [9:0] d2_db, d2_rise, d2_fall;
    logic       d2_any;

    int n_cmp;
    int n_bad;

    input_debouncer #(.STABLE_CYCLES(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_db   (d4_db),
        .sw_rise (d4_rise),
        .sw_fall (d4_fall),
        .any_chg (d4_any)
    );

    input_debouncer #(.STABLE_CYCLES(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_db   (d2_db),
        .sw_rise (d2_rise),
        .sw_fall (d2_fall),
        .any_chg (d2_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last S synchronized
    // samples all disagree with the current debounced level.
    int unsigned s_cfg [2];
    logic [9:0]  hist  [2][8];
    logic [9:0]  m_db  [2];
    logic [9:0]  m_rise[2];
    logic [9:0]  m_fall[2];
    logic        m_any [2];
    logic [9:0]  m_s1;
    logic [9:0]  m_s2;

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j < 8; j++) hist[n][j] = '0;
            m_db[n]   = '0;
            m_rise[n] = '0;
            m_fall[n] = '0;
            m_any[n]  = 1'b0;
        end
        m_s1 = '0;
        m_s2 = '0;
    endtask

    task automatic model_edge();
        logic [9:0] nxt;
        logic       all_diff;
        for (int n = 0; n < 2; n++) begin
            for (int j = 7; j > 0; j--) hist[n][j] = hist[n][j-1];
            hist[n][0] = m_s2;
            nxt = m_db[n];
            for (int b = 0; b < 10; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(s_cfg[n]); j++) begin
                    if (hist[n][j][b] == m_db[n][b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = ~m_db[n][b];
            end
            m_rise[n] = nxt & ~m_db[n];
            m_fall[n] = ~nxt & m_db[n];
            m_any[n]  = (m_rise[n] | m_fall[n]) != '0;
            m_db[n]   = nxt;
        end
        m_s2 = m_s1;
        m_s1 = sw_in;
    endtask

    task automatic check_model();
        check_eq("db4",   d4_db,        m_db[0]);
        check_eq("rise4", d4_rise,      m_rise[0]);
        check_eq("fall4", d4_fall,      m_fall[0]);
        check_eq("any4",  10'(d4_any),  10'(m_any[0]));
        check_eq("db2",   d2_db,        m_db[1]);
        check_eq("rise2", d2_rise,      m_rise[1]);
        check_eq("fall2", d2_fall,      m_fall[1]);
        check_eq("any2",  10'(d2_any),  10'(m_any[1]));
    endtask

    // Drive a value, take one rising edge, compare just after it.
    task automatic step(input logic [9:0] v);
        sw_in = v;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_eq("rst_db4",   d4_db,       10'h000);
        check_eq("rst_rise4", d4_rise,     10'h000);
        check_eq("rst_fall4", d4_fall,     10'h000);
        check_eq("rst_any4",  10'(d4_any), 10'h000);
        check_eq("rst_db2",   d2_db,       10'h000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [9:0] cur;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        s_cfg[0] = 4;
        s_cfg[1] = 2;
        rst      = 1'b1;
        sw_in    = '0;
        model_reset();
        #3;
        do_reset();

        // Idle after reset: nothing moves.
        for (int k = 0; k < 6; k++) begin
            step(10'h000);
            check_eq("idle_db", d4_db, 10'h000);
            check_eq("idle_any", 10'(d4_any), 10'h000);
        end

        // Single bit, latency check for both builds.
        for (int e = 1; e <= 7; e++) begin
            step(10'h001);
            if (e < 6) check_eq("lat_db_pre", d4_db, 10'h000);
            if (e == 6) begin
                check_eq("lat_db",   d4_db,       10'h001);
                check_eq("lat_rise", d4_rise,     10'h001);
                check_eq("lat_any",  10'(d4_any), 10'h001);
            end
            if (e == 7) begin
                check_eq("lat_rise_off", d4_rise,     10'h000);
                check_eq("lat_any_off",  10'(d4_any), 10'h000);
            end
            if (e == 3) check_eq("s2_db_pre", d2_db, 10'h000);
            if (e == 4) check_eq("s2_db", d2_db, 10'h001);
        end

        // All high, then a 3-cycle dropout on bit 9 must be rejected.
        for (int k = 0; k < 8; k++) step(10'h3FF);
        check_eq("all_high", d4_db, 10'h3FF);
        for (int k = 0; k < 3; k++) step(10'h1FF);
        for (int k = 0; k < 8; k++) begin
            step(10'h3FF);
            check_eq("glitch_db",   d4_db,       10'h3FF);
            check_eq("glitch_fall", d4_fall,     10'h000);
            check_eq("glitch_any",  10'(d4_any), 10'h000);
        end

        // Multi-bit simultaneous change.
        do_reset();
        for (int e = 1; e <= 7; e++) begin
            step(10'h2A5);
            if (e == 5) check_eq("multi_db_pre", d4_db, 10'h000);
            if (e == 6) begin
                check_eq("multi_db",   d4_db,       10'h2A5);
                check_eq("multi_rise", d4_rise,     10'h2A5);
                check_eq("multi_any",  10'(d4_any), 10'h001);
            end
            if (e == 7) check_eq("multi_any_off", 10'(d4_any), 10'h000);
        end

        // Reset in the middle of a count discards it.
        do_reset();
        for (int k = 0; k < 4; k++) step(10'h008);
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            step(10'h008);
            if (e == 5) check_eq("midrst_pre", d4_db, 10'h000);
            if (e == 6) check_eq("midrst_db", d4_db, 10'h008);
        end

        // Bit 5 toggling every cycle never settles; then held high.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            step((k % 2 == 0) ? 10'h020 : 10'h000);
            check_eq("tog_db", d4_db, 10'h000);
        end
        check_eq("tog_db2", d2_db, 10'h000);
        for (int e = 1; e <= 6; e++) step(10'h020);
        check_eq("tog_rise", d4_rise, 10'h020);

        // Randomized per-bit slow toggling with occasional glitches and resets.
        cur = sw_in;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 10; b++) begin
                if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            step(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
